// File: rtl/keypad_load_enc_pkg.sv
// rtl/keypad_load_enc_pkg.sv - shared state encoding, column reset value and key-code table
//
// Purpose: definitions shared by the keypad scanner/encoder.
// Contents:
//   state_e     FSM states of the scanner
//   COL_RESET   column drive value after reset (column 0 driven low)
//   key_code    16-entry row/column -> key code table
//   col_index   one-hot active-low column drive -> column index
//   single_low  true when exactly one row bit is low
//   row_index   index of the low bit of a single-low row value
package keypad_load_enc_pkg;

  typedef enum logic [2:0] {
    ST_SCAN     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_ACCEPT   = 3'd2,
    ST_HOLD     = 3'd3,
    ST_RELEASE  = 3'd4
  } state_e;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Keypad face layout; row 3 is {*, 0, #, D} encoded as {E, 0, F, D}.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] col);
    logic [1:0] idx;
    case (col)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic single_low(input logic [3:0] rows);
    logic [3:0] low;
    low = ~rows;
    return (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] rows);
    logic [1:0] idx;
    case (rows)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_load_enc_sync_2ff.sv
// rtl/keypad_load_enc_sync_2ff.sv - two-flop synchronizer, resets to all-ones
//
// Purpose: brings the asynchronous keypad row lines into the clk domain.
// Ports:
//   clk  in  1  system clock
//   rst  in  1  synchronous active-high reset (flops go to all-ones = no key)
//   d_i  in  W  asynchronous input
//   q_o  out W  synchronized output
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_load_enc.sv
// rtl/keypad_load_enc.sv - 4x4 keypad scanner with debounce, key encoding and load strobe
//
// Purpose: scans an active-low 4x4 keypad, debounces one press and emits its
// 4-bit code with a one-cycle load strobe (one strobe per physical press).
// Ports:
//   clk       in   1  system clock
//   rst       in   1  synchronous active-high reset
//   row_in    in   4  keypad rows, active-low, asynchronous
//   col_out   out  4  column drive, one-hot active-low
//   data_out  out  4  code of last accepted key
//   load_out  out  1  one-cycle pulse when data_out updates
//   key_down  out  1  high from accept until release debounce completes
module keypad_load_enc
  import keypad_load_enc_pkg::*;
#(
  parameter int N_MAX    = 5000,
  parameter int SCAN_DIV = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] data_out,
  output logic       load_out,
  output logic       key_down
);

  localparam int CNT_MAX = (N_MAX > SCAN_DIV) ? N_MAX : SCAN_DIV;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(N_MAX - 1);

  logic [3:0]    rs;
  state_e        state_q;
  logic [CW-1:0] scan_cnt_q;
  logic [CW-1:0] deb_cnt_q;
  logic [3:0]    col_q;
  logic [3:0]    cap_row_q;
  logic [1:0]    cap_col_q;
  logic [3:0]    data_q;
  logic          load_q;
  logic          key_down_q;

  sync_2ff #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (row_in),
    .q_o (rs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      col_q      <= COL_RESET;
      cap_row_q  <= 4'hF;
      cap_col_q  <= 2'd0;
      data_q     <= 4'h0;
      load_q     <= 1'b0;
      key_down_q <= 1'b0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        ST_SCAN: begin
          // A detected row wins over rotation so the column that saw it stays driven.
          if (rs != 4'hF) begin
            cap_row_q <= rs;
            cap_col_q <= col_index(col_q);
            deb_cnt_q <= '0;
            state_q   <= ST_DEBOUNCE;
          end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            col_q      <= {col_q[2:0], col_q[3]};
          end else begin
            scan_cnt_q <= scan_cnt_q + CW'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (rs != cap_row_q) begin
            scan_cnt_q <= '0;
            state_q    <= ST_SCAN;
          end else if (deb_cnt_q == DEB_LAST) begin
            // Outputs are loaded on entry so they are registered during the ACCEPT cycle.
            state_q    <= ST_ACCEPT;
            key_down_q <= 1'b1;
            if (single_low(cap_row_q)) begin
              data_q <= key_code(row_index(cap_row_q), cap_col_q);
              load_q <= 1'b1;
            end
          end else begin
            deb_cnt_q <= deb_cnt_q + CW'(1);
          end
        end
        ST_ACCEPT: begin
          state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (rs == 4'hF) begin
            deb_cnt_q <= '0;
            state_q   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (rs != 4'hF) begin
            state_q <= ST_HOLD;
          end else if (deb_cnt_q == DEB_LAST) begin
            key_down_q <= 1'b0;
            scan_cnt_q <= '0;
            col_q      <= {col_q[2:0], col_q[3]};
            state_q    <= ST_SCAN;
          end else begin
            deb_cnt_q <= deb_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_SCAN;
        end
      endcase
    end
  end

  assign col_out  = col_q;
  assign data_out = data_q;
  assign load_out = load_q;
  assign key_down = key_down_q;

endmodule

// File: tb/tb_keypad_load_enc.sv
// tb/tb_keypad_load_enc.sv - self-checking bench for keypad_load_enc
module tb_keypad_load_enc;

  localparam int N_MAX    = 4;
  localparam int SCAN_DIV = 3;
  localparam int LAT      = 2 + N_MAX + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in = 4'hF;
  logic [3:0] col_out;
  logic [3:0] data_out;
  logic       load_out;
  logic       key_down;

  keypad_load_enc #(.N_MAX(N_MAX), .SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .data_out (data_out),
    .load_out (load_out),
    .key_down (key_down)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  typedef struct {
    logic [3:0] code;
    int         when;
  } exp_t;
  exp_t exp_q[$];

  // Scoreboard consumer: every load pulse must match the oldest expected press.
  always @(negedge clk) begin
    exp_t e;
    if (load_out === 1'b1) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_load cyc=%0d data_out=%h, required no pulse", cyc, data_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e.code || cyc != e.when) begin
          errors++;
          $display("FAIL load_match data=%h cyc=%0d, required data=%h cyc=%0d",
                   data_out, cyc, e.code, e.when);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Returns on the first negedge at which col_out has just become t.
  task automatic wait_col(input logic [3:0] t);
    int n;
    n = 0;
    while (col_out === t && n < 40) begin @(negedge clk); n++; end
    while (col_out !== t && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (col_out !== t) begin
      errors++;
      $display("FAIL wait_col col_out=%b, required %b", col_out, t);
    end
  endtask

  task automatic release_key();
    int n;
    n = 0;
    row_in = 4'hF;
    while (key_down !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (key_down !== 1'b0) begin
      errors++;
      $display("FAIL release_timeout key_down=%b, required 0", key_down);
    end
  endtask

  task automatic test_reset();
    int r;
    int offs[5];
    logic [3:0] cols[5];
    offs = '{2, 3, 6, 9, 12};
    cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst = 1'b1;
    row_in = 4'hF;
    repeat (3) @(negedge clk);
    checks += 4;
    if (col_out !== 4'b1110) begin errors++; $display("FAIL reset_col col_out=%b, required 1110", col_out); end
    if (data_out !== 4'h0) begin errors++; $display("FAIL reset_data data_out=%h, required 0", data_out); end
    if (load_out !== 1'b0) begin errors++; $display("FAIL reset_load load_out=%b, required 0", load_out); end
    if (key_down !== 1'b0) begin errors++; $display("FAIL reset_keydown key_down=%b, required 0", key_down); end
    rst = 1'b0;
    r = cyc;
    for (int i = 0; i < 5; i++) begin
      wait_until(r + offs[i]);
      checks++;
      if (col_out !== cols[i]) begin
        errors++;
        $display("FAIL scan_rotate step=%0d col_out=%b, required %b", i, col_out, cols[i]);
      end
    end
  endtask

  task automatic test_key5();
    int e;
    int rel;
    int p0;
    wait_col(4'b1101);
    e = cyc;
    p0 = pulses;
    row_in = 4'b1101;
    exp_q.push_back('{4'h5, e + LAT});
    wait_until(e + LAT + 1);
    checks++;
    if (data_out !== 4'h5) begin errors++; $display("FAIL key5_data data_out=%h, required 5", data_out); end
    rel = e + 20;
    wait_until(rel);
    row_in = 4'hF;
    wait_until(rel + N_MAX + 2);
    checks++;
    if (key_down !== 1'b1) begin errors++; $display("FAIL key5_keydown_held key_down=%b, required 1", key_down); end
    wait_until(rel + N_MAX + 3);
    checks += 3;
    if (key_down !== 1'b0) begin errors++; $display("FAIL key5_keydown_drop key_down=%b, required 0", key_down); end
    if (col_out !== 4'b1011) begin errors++; $display("FAIL key5_next_col col_out=%b, required 1011", col_out); end
    if (pulses - p0 != 1) begin errors++; $display("FAIL key5_pulses count=%0d, required 1", pulses - p0); end
  endtask

  task automatic test_bounce();
    int e;
    int p0;
    wait_col(4'b1101);
    e = cyc;
    p0 = pulses;
    exp_q.push_back('{4'h5, e + 8 + LAT});
    for (int i = 0; i < 10; i++) begin
      wait_until(e + i);
      row_in = (((i / 2) % 2) == 0) ? 4'b1101 : 4'hF;
    end
    wait_until(e + 10);
    row_in = 4'b1101;
    wait_until(e + 25);
    release_key();
    checks++;
    if (pulses - p0 != 1) begin errors++; $display("FAIL bounce_pulses count=%0d, required 1", pulses - p0); end
  endtask

  task automatic test_hash();
    int e;
    int p0;
    bit moved;
    int n;
    wait_col(4'b1011);
    e = cyc;
    p0 = pulses;
    row_in = 4'b0111;
    exp_q.push_back('{4'hF, e + LAT});
    moved = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (col_out !== 4'b1011) moved = 1'b1;
    end
    row_in = 4'hF;
    n = 0;
    while (key_down === 1'b1 && n < 40) begin
      if (col_out !== 4'b1011) moved = 1'b1;
      @(negedge clk);
      n++;
    end
    checks += 4;
    if (moved) begin errors++; $display("FAIL hash_frozen col_out moved, required 1011 until release"); end
    if (col_out !== 4'b0111) begin errors++; $display("FAIL hash_next_col col_out=%b, required 0111", col_out); end
    if (data_out !== 4'hF) begin errors++; $display("FAIL hash_data data_out=%h, required F", data_out); end
    if (pulses - p0 != 1) begin errors++; $display("FAIL hash_pulses count=%0d, required 1", pulses - p0); end
  endtask

  task automatic test_multi();
    int e;
    int p0;
    wait_col(4'b1110);
    e = cyc;
    p0 = pulses;
    row_in = 4'b1100;
    wait_until(e + LAT - 1);
    checks++;
    if (key_down !== 1'b0) begin errors++; $display("FAIL multi_keydown_early key_down=%b, required 0", key_down); end
    wait_until(e + LAT);
    checks++;
    if (key_down !== 1'b1) begin errors++; $display("FAIL multi_keydown key_down=%b, required 1", key_down); end
    wait_until(e + LAT + 3);
    release_key();
    checks += 2;
    if (data_out !== 4'hF) begin errors++; $display("FAIL multi_data data_out=%h, required F", data_out); end
    if (pulses - p0 != 0) begin errors++; $display("FAIL multi_pulses count=%0d, required 0", pulses - p0); end
  endtask

  task automatic check_reset_outputs(input int tag);
    checks += 4;
    if (col_out !== 4'b1110) begin errors++; $display("FAIL rst%0d_col col_out=%b, required 1110", tag, col_out); end
    if (data_out !== 4'h0) begin errors++; $display("FAIL rst%0d_data data_out=%h, required 0", tag, data_out); end
    if (load_out !== 1'b0) begin errors++; $display("FAIL rst%0d_load load_out=%b, required 0", tag, load_out); end
    if (key_down !== 1'b0) begin errors++; $display("FAIL rst%0d_keydown key_down=%b, required 0", tag, key_down); end
  endtask

  task automatic test_rst_mid();
    int e;
    int p0;
    wait_col(4'b1101);
    e = cyc;
    p0 = pulses;
    row_in = 4'b1101;
    wait_until(e + 4);
    rst = 1'b1;
    row_in = 4'hF;
    @(negedge clk);
    check_reset_outputs(0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (pulses - p0 != 0) begin errors++; $display("FAIL rst0_pulses count=%0d, required 0", pulses - p0); end

    wait_col(4'b1101);
    e = cyc;
    p0 = pulses;
    row_in = 4'b1101;
    exp_q.push_back('{4'h5, e + LAT});
    wait_until(e + 12);
    checks++;
    if (key_down !== 1'b1) begin errors++; $display("FAIL rst1_before key_down=%b, required 1", key_down); end
    rst = 1'b1;
    row_in = 4'hF;
    @(negedge clk);
    check_reset_outputs(1);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (pulses - p0 != 1) begin errors++; $display("FAIL rst1_pulses count=%0d, required 1", pulses - p0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_key5();
    test_bounce();
    test_hash();
    test_multi();
    test_rst_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_loads pending=%0d, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
